// File: rtl/ccc_cfg_pkg.sv
// Shared types for the CCC dynamic-configuration APB master.
// State encoding, bus widths and the registered command bundle.
package ccc_cfg_pkg;

    localparam int CCC_ADDR_W = 6;
    localparam int CCC_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BUSY = 3'd1,
        ST_SETUP     = 3'd2,
        ST_ACCESS    = 3'd3,
        ST_RESP      = 3'd4,
        ST_LOCK_WAIT = 3'd5
    } ccc_state_e;

    typedef struct packed {
        logic                  write;
        logic                  last;
        logic [CCC_ADDR_W-1:0] addr;
        logic [CCC_DATA_W-1:0] wdata;
    } ccc_cmd_t;

endpackage

// File: rtl/ccc_cfg_sync2.sv
// Two-flop synchronizer for the asynchronous CCC BUSY and LOCK pins.
// Reset value is chosen per instance so BUSY resets pessimistically high.
module ccc_cfg_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the pin through two flops to settle metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/nand_flash_ccc_apb_cfg_master.sv
// APB initiator reprogramming the NAND-flash clock CCC/PLL.
// Holds the PLL in reset across a command sequence, then supervises LOCK.
module nand_flash_ccc_apb_cfg_master
    import ccc_cfg_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic                  CMD_LAST,
    input  logic [CCC_ADDR_W-1:0] CMD_ADDR,
    input  logic [CCC_DATA_W-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    output logic [CCC_DATA_W-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [CCC_ADDR_W-1:0] PADDR,
    output logic [CCC_DATA_W-1:0] PWDATA,
    input  logic [CCC_DATA_W-1:0] PRDATA,
    input  logic                  BUSY,
    input  logic                  LOCK,
    output logic                  PLL_ARST_N,
    output logic                  SEQ_DONE,
    output logic                  LOCK_ERR
);

    localparam int MAX_TO = (BUSY_TIMEOUT > LOCK_TIMEOUT) ?
                            BUSY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_TO) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] BUSY_TO_C = CNT_W'(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] LOCK_TO_C = CNT_W'(LOCK_TIMEOUT);

    logic busy_s;
    logic lock_s;

    ccc_state_e state_q, state_d;
    ccc_cmd_t   cmd_q, cmd_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic seq_active_q, seq_active_d;
    logic cmd_ready_q, cmd_ready_d;
    logic rsp_valid_q, rsp_valid_d;
    logic rsp_err_q, rsp_err_d;
    logic psel_q, psel_d;
    logic penable_q, penable_d;
    logic pwrite_q, pwrite_d;
    logic pll_arst_n_q, pll_arst_n_d;
    logic seq_done_q, seq_done_d;
    logic lock_err_q, lock_err_d;

    logic [CCC_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CCC_ADDR_W-1:0] paddr_q, paddr_d;
    logic [CCC_DATA_W-1:0] pwdata_q, pwdata_d;

    ccc_cfg_sync2 #(.RST_VAL(1'b1)) u_busy_sync (
        .clk (PCLK),
        .rst (PRESET),
        .d   (BUSY),
        .q   (busy_s)
    );

    ccc_cfg_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
        .clk (PCLK),
        .rst (PRESET),
        .d   (LOCK),
        .q   (lock_s)
    );

    // Sequencer: next state, shared timeout counter and registered outputs
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cnt_d        = cnt_q;
        seq_active_d = seq_active_q;
        pll_arst_n_d = pll_arst_n_q;
        lock_err_d   = lock_err_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        seq_done_d   = 1'b0;

        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    cmd_d = '{write: CMD_WRITE,
                              last:  CMD_LAST,
                              addr:  CMD_ADDR,
                              wdata: CMD_WDATA};
                    cnt_d   = '0;
                    state_d = ST_WAIT_BUSY;
                    if (!seq_active_q) begin
                        seq_active_d = 1'b1;
                        pll_arst_n_d = 1'b0;
                        lock_err_d   = 1'b0;
                    end
                end
            end
            ST_WAIT_BUSY: begin
                cnt_d = cnt_inc;
                if (!busy_s) begin
                    state_d  = ST_SETUP;
                    paddr_d  = cmd_q.addr;
                    pwdata_d = cmd_q.wdata;
                    pwrite_d = cmd_q.write;
                end else if (cnt_inc >= BUSY_TO_C) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_rdata_d = cmd_q.write ? '0 : PRDATA;
            end
            ST_RESP: begin
                if (cmd_q.last) begin
                    pll_arst_n_d = 1'b1;
                    seq_active_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = ST_LOCK_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK_WAIT: begin
                cnt_d = cnt_inc;
                if (lock_s) begin
                    seq_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (cnt_inc >= LOCK_TO_C) begin
                    lock_err_d = 1'b1;
                    seq_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; PLL reset is released while in reset
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            cnt_q        <= '0;
            seq_active_q <= 1'b0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pll_arst_n_q <= 1'b1;
            seq_done_q   <= 1'b0;
            lock_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cnt_q        <= cnt_d;
            seq_active_q <= seq_active_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pll_arst_n_q <= pll_arst_n_d;
            seq_done_q   <= seq_done_d;
            lock_err_q   <= lock_err_d;
        end
    end

    assign CMD_READY  = cmd_ready_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_RDATA  = rsp_rdata_q;
    assign RSP_ERR    = rsp_err_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign PLL_ARST_N = pll_arst_n_q;
    assign SEQ_DONE   = seq_done_q;
    assign LOCK_ERR   = lock_err_q;

endmodule

// File: tb/tb_nand_flash_ccc_apb_cfg_master.sv
// Directed bench for the CCC APB configuration master.
// Short timeouts keep BUSY and LOCK supervision cases fast.
module tb_nand_flash_ccc_apb_cfg_master;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_WRITE;
    logic       CMD_LAST;
    logic [5:0] CMD_ADDR;
    logic [7:0] CMD_WDATA;
    logic       RSP_VALID;
    logic [7:0] RSP_RDATA;
    logic       RSP_ERR;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       BUSY;
    logic       LOCK;
    logic       PLL_ARST_N;
    logic       SEQ_DONE;
    logic       LOCK_ERR;

    int n_vec = 0;
    int n_err = 0;
    int rsp_cnt = 0;
    int psel_cnt = 0;

    nand_flash_ccc_apb_cfg_master #(
        .BUSY_TIMEOUT(8),
        .LOCK_TIMEOUT(20)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_WRITE  (CMD_WRITE),
        .CMD_LAST   (CMD_LAST),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_WDATA  (CMD_WDATA),
        .RSP_VALID  (RSP_VALID),
        .RSP_RDATA  (RSP_RDATA),
        .RSP_ERR    (RSP_ERR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .BUSY       (BUSY),
        .LOCK       (LOCK),
        .PLL_ARST_N (PLL_ARST_N),
        .SEQ_DONE   (SEQ_DONE),
        .LOCK_ERR   (LOCK_ERR)
    );

    always #5 PCLK = ~PCLK;

    // Count response pulses and selected APB cycles mid-cycle
    always @(negedge PCLK) begin
        if (RSP_VALID) rsp_cnt++;
        if (PSEL) psel_cnt++;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and wait for its response (bounded)
    task automatic do_cmd(input logic w, input logic l,
                          input logic [5:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd,
                          output logic er, output int arst_hi);
        int n;
        arst_hi = 0;
        n = 0;
        while (!CMD_READY && n < 100) begin
            if (PLL_ARST_N) arst_hi++;
            tick();
            n++;
        end
        chk("cmd_ready_wait", {31'd0, CMD_READY}, 32'd1);
        CMD_VALID = 1'b1;
        CMD_WRITE = w;
        CMD_LAST  = l;
        CMD_ADDR  = a;
        CMD_WDATA = d;
        tick();
        CMD_VALID = 1'b0;
        n = 1;
        while (!RSP_VALID && n < 100) begin
            if (PLL_ARST_N) arst_hi++;
            tick();
            n++;
        end
        if (PLL_ARST_N) arst_hi++;
        lat = n;
        rd  = RSP_RDATA;
        er  = RSP_ERR;
    endtask

    initial begin
        int lat;
        int ahi;
        int n;
        int base_rsp;
        int base_psel;
        int acc_n;
        int acc [3];
        logic [7:0] rd;
        logic er;

        PRESET    = 1'b1;
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_LAST  = 1'b0;
        CMD_ADDR  = '0;
        CMD_WDATA = '0;
        PRDATA    = '0;
        BUSY      = 1'b0;
        LOCK      = 1'b0;
        acc       = '{default: 0};

        // Reset values
        #2;
        chk("rst_ready", {31'd0, CMD_READY}, 32'd0);
        chk("rst_psel", {31'd0, PSEL}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
        chk("rst_arst_n", {31'd0, PLL_ARST_N}, 32'd1);
        chk("rst_seq_done", {31'd0, SEQ_DONE}, 32'd0);
        chk("rst_lock_err", {31'd0, LOCK_ERR}, 32'd0);
        tick();
        tick();
        PRESET = 1'b0;
        tick();
        tick();
        tick();

        // Single write, LOCK rises 10 cycles after release
        chk("t1_ready_c0", {31'd0, CMD_READY}, 32'd1);
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b1;
        CMD_LAST  = 1'b1;
        CMD_ADDR  = 6'h05;
        CMD_WDATA = 8'hA7;
        tick();
        CMD_VALID = 1'b0;
        chk("t1_ready_c1", {31'd0, CMD_READY}, 32'd0);
        chk("t1_arst_c1", {31'd0, PLL_ARST_N}, 32'd0);
        chk("t1_psel_c1", {31'd0, PSEL}, 32'd0);
        tick();
        chk("t1_psel_c2", {31'd0, PSEL}, 32'd1);
        chk("t1_pen_c2", {31'd0, PENABLE}, 32'd0);
        chk("t1_paddr", {26'd0, PADDR}, 32'h05);
        chk("t1_pwdata", {24'd0, PWDATA}, 32'hA7);
        chk("t1_pwrite", {31'd0, PWRITE}, 32'd1);
        tick();
        chk("t1_psel_c3", {31'd0, PSEL}, 32'd1);
        chk("t1_pen_c3", {31'd0, PENABLE}, 32'd1);
        tick();
        chk("t1_rsp_c4", {31'd0, RSP_VALID}, 32'd1);
        chk("t1_err_c4", {31'd0, RSP_ERR}, 32'd0);
        chk("t1_psel_c4", {31'd0, PSEL}, 32'd0);
        chk("t1_arst_c4", {31'd0, PLL_ARST_N}, 32'd0);
        tick();
        chk("t1_arst_c5", {31'd0, PLL_ARST_N}, 32'd1);
        chk("t1_rsp_c5", {31'd0, RSP_VALID}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        LOCK = 1'b1;
        n = 0;
        while (!SEQ_DONE && n < 40) begin
            tick();
            n++;
        end
        chk("t1_seq_done_lat", n, 32'd3);
        chk("t1_lock_err", {31'd0, LOCK_ERR}, 32'd0);
        tick();
        chk("t1_seq_done_pulse", {31'd0, SEQ_DONE}, 32'd0);
        LOCK = 1'b0;
        tick();
        tick();
        tick();

        // Three-command sequence ending in a read; LOCK never asserts
        PRDATA   = 8'h5C;
        base_rsp = rsp_cnt;
        do_cmd(1'b1, 1'b0, 6'h00, 8'h11, lat, rd, er, ahi);
        chk("t2_c1_lat", lat, 32'd4);
        chk("t2_c1_arst_hi", ahi, 32'd0);
        do_cmd(1'b1, 1'b0, 6'h01, 8'h22, lat, rd, er, ahi);
        chk("t2_c2_lat", lat, 32'd4);
        chk("t2_c2_arst_hi", ahi, 32'd0);
        do_cmd(1'b0, 1'b1, 6'h02, 8'h00, lat, rd, er, ahi);
        chk("t2_c3_lat", lat, 32'd4);
        chk("t2_c3_arst_hi", ahi, 32'd0);
        chk("t2_c3_rdata", {24'd0, rd}, 32'h5C);
        chk("t2_c3_err", {31'd0, er}, 32'd0);
        tick();
        chk("t2_arst_rise", {31'd0, PLL_ARST_N}, 32'd1);
        n = 0;
        while (!SEQ_DONE && n < 60) begin
            tick();
            n++;
        end
        chk("t4_lock_to_lat", n, 32'd20);
        chk("t4_lock_err", {31'd0, LOCK_ERR}, 32'd1);
        chk("t2_rsp_pulses", rsp_cnt - base_rsp, 32'd3);
        tick();
        chk("t4_lock_err_sticky", {31'd0, LOCK_ERR}, 32'd1);

        // BUSY held high: read abandoned without any APB transfer
        BUSY = 1'b1;
        tick();
        tick();
        tick();
        base_psel = psel_cnt;
        do_cmd(1'b0, 1'b0, 6'h10, 8'h33, lat, rd, er, ahi);
        chk("t3_lat", lat, 32'd9);
        chk("t3_err", {31'd0, er}, 32'd1);
        chk("t3_rdata", {24'd0, rd}, 32'h00);
        chk("t3_no_psel", psel_cnt - base_psel, 32'd0);
        chk("t4_lock_err_clr", {31'd0, LOCK_ERR}, 32'd0);
        chk("t3_arst_low", {31'd0, PLL_ARST_N}, 32'd0);
        BUSY = 1'b0;
        LOCK = 1'b1;
        tick();
        tick();
        tick();
        do_cmd(1'b1, 1'b1, 6'h08, 8'h99, lat, rd, er, ahi);
        chk("t3_close_lat", lat, 32'd4);
        chk("t3_close_err", {31'd0, er}, 32'd0);
        tick();
        chk("t3_done_l1", {31'd0, SEQ_DONE}, 32'd0);
        tick();
        chk("t3_done_l2", {31'd0, SEQ_DONE}, 32'd1);
        chk("t3_lock_err", {31'd0, LOCK_ERR}, 32'd0);
        LOCK = 1'b0;
        tick();
        tick();
        tick();

        // PRESET during ACCESS drops the transfer silently
        chk("t5_ready", {31'd0, CMD_READY}, 32'd1);
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b1;
        CMD_LAST  = 1'b0;
        CMD_ADDR  = 6'h03;
        CMD_WDATA = 8'h44;
        tick();
        CMD_VALID = 1'b0;
        tick();
        tick();
        chk("t5_pen_access", {31'd0, PENABLE}, 32'd1);
        chk("t5_arst_access", {31'd0, PLL_ARST_N}, 32'd0);
        base_rsp = rsp_cnt;
        #2;
        PRESET = 1'b1;
        #1;
        chk("t5_psel_rst", {31'd0, PSEL}, 32'd0);
        chk("t5_pen_rst", {31'd0, PENABLE}, 32'd0);
        chk("t5_arst_rst", {31'd0, PLL_ARST_N}, 32'd1);
        tick();
        PRESET = 1'b0;
        LOCK   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_no_rsp", rsp_cnt - base_rsp, 32'd0);
        do_cmd(1'b1, 1'b1, 6'h07, 8'h5A, lat, rd, er, ahi);
        chk("t5_rerun_lat", lat, 32'd4);
        chk("t5_rerun_err", {31'd0, er}, 32'd0);
        tick();
        tick();
        chk("t5_rerun_done", {31'd0, SEQ_DONE}, 32'd1);
        chk("t5_paddr_hold", {26'd0, PADDR}, 32'h07);
        chk("t5_pwdata_hold", {24'd0, PWDATA}, 32'h5A);
        LOCK = 1'b0;
        tick();
        tick();
        tick();

        // CMD_VALID held high: one accept every 5 cycles
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b1;
        CMD_LAST  = 1'b0;
        CMD_ADDR  = 6'h0A;
        CMD_WDATA = 8'h3C;
        acc_n = 0;
        for (int i = 0; i < 15; i++) begin
            if (CMD_READY) begin
                if (acc_n < 3) acc[acc_n] = i;
                acc_n++;
            end
            tick();
        end
        CMD_VALID = 1'b0;
        chk("t6_accepts", acc_n, 32'd3);
        chk("t6_first", acc[0], 32'd0);
        chk("t6_gap1", acc[1] - acc[0], 32'd5);
        chk("t6_gap2", acc[2] - acc[1], 32'd5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nand_flash_ccc_apb_cfg_master.md
# nand_flash_ccc_apb_cfg_master

APB initiator that dynamically reconfigures the fabric CCC/PLL feeding the NAND flash controller clock. It accepts a stream of register read/write commands from the system controller and issues each one as a 6-bit-address, 8-bit-data APB transfer on the CCC configuration port. It holds the PLL in reset for the duration of a command sequence, then releases it and supervises LOCK with a timeout. It sits between the system controller and the CCC dynamic-configuration pins (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/BUSY).

## Interface
- BUSY_TIMEOUT, 255: maximum cycles to wait for synchronized BUSY low before a command is abandoned.
- LOCK_TIMEOUT, 65535: maximum cycles to wait for synchronized LOCK high after PLL reset release.
- PCLK  in  1  clock for all logic and for the APB configuration port.
- PRESET  in  1  reset, **asynchronous, active-high**. This is the block's only reset; it uses this one clock.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_LAST  in  1  final command of a sequence.
- CMD_ADDR  in  6  CCC register address.
- CMD_WDATA  in  8  write data.
- RSP_VALID  out  1  one-cycle completion pulse, one per command; no backpressure.
- RSP_RDATA  out  8  read data (0 for writes and errors).
- RSP_ERR  out  1  command abandoned on BUSY timeout; qualified by RSP_VALID.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  6  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- BUSY  in  1  CCC busy.
- LOCK  in  1  PLL lock.
- PLL_ARST_N  out  1  PLL reset, active low.
- SEQ_DONE  out  1  one-cycle pulse when lock supervision ends.
- LOCK_ERR  out  1  sticky lock-timeout flag; cleared when the next sequence accepts its first command.

## Operation
- BUSY and LOCK pass through a 2-flop synchronizer (busy_s, lock_s).
- States: IDLE, WAIT_BUSY, SETUP, ACCESS, RESP, LOCK_WAIT.
- IDLE:
  - CMD_READY=1. On accept, register the command and go to WAIT_BUSY.
  - If no sequence is active: set seq_active, drive PLL_ARST_N=0, and clear LOCK_ERR.
- WAIT_BUSY:
  - busy_s=0 → SETUP.
  - Counter reaches BUSY_TIMEOUT → RESP with the error flag set; no APB transfer is issued.
- SETUP: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA valid. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1. There is no PREADY; each transfer is fixed at one setup plus one access cycle. Reads capture PRDATA at the end of ACCESS.
- RESP: RSP_VALID=1, RSP_RDATA/RSP_ERR valid.
  - CMD_LAST=0 → IDLE.
  - CMD_LAST=1 → drive PLL_ARST_N=1, clear seq_active, reset the counter, go to LOCK_WAIT.
- LOCK_WAIT:
  - lock_s=1 → SEQ_DONE pulse, IDLE.
  - Counter reaches LOCK_TIMEOUT → LOCK_ERR=1, SEQ_DONE pulse, IDLE.
- CMD_LAST on a read or on an errored command still ends the sequence.
- One shared counter is used for both timeouts. Its width is $clog2 of the larger parameter plus 1; it saturates and never wraps.
- PADDR/PWDATA/PWRITE hold their last values outside transfers. PSEL/PENABLE are 0 outside SETUP/ACCESS.

## Timing
- Reset values: all outputs 0 except PLL_ARST_N=1. The counter is 0 and seq_active is 0.
- PRESET asserted mid-transfer: PSEL/PENABLE drop immediately (asynchronous), PLL_ARST_N returns to 1, and the pending command is lost with no RSP_VALID.
- All outputs are registered.
- Minimum latency with busy_s already low:
  - accept at cycle 0; WAIT_BUSY cycle 1; SETUP cycle 2; ACCESS cycle 3; RSP_VALID cycle 4.
  - The next accept is possible at cycle 5.
- BUSY rising at the pin takes 2 cycles to reach busy_s. A transfer already in SETUP completes regardless.
- PLL_ARST_N falls the cycle after the first accept. It rises in the cycle after RESP of the last command.
- The first LOCK_WAIT cycle counts as 1. LOCK_ERR is set exactly LOCK_TIMEOUT cycles after PLL_ARST_N rises if lock_s never asserts.
- If lock_s and timeout occur in the same cycle, lock wins: no error is flagged.

## Structure
- Package ccc_cfg_pkg holds:
  - the state enum;
  - CCC_ADDR_W=6 and CCC_DATA_W=8;
  - the command struct {write, last, addr, wdata}.
- Sub-module ccc_cfg_sync2: a 2-flop synchronizer instantiated for BUSY and LOCK. Its reset is PRESET; it resets BUSY to 1 and LOCK to 0.

## Test plan
- Single write addr 0x05 data 0xA7 with CMD_LAST=1, BUSY=0, LOCK rising 10 cycles after PLL_ARST_N release:
  - PSEL cycle 2, PENABLE cycle 3, PADDR=0x05, PWDATA=0xA7;
  - RSP_VALID cycle 4 with RSP_ERR=0;
  - SEQ_DONE about 12 cycles later; LOCK_ERR=0.
- Three-command sequence (write 0x00=0x11, write 0x01=0x22, read 0x02 returning 0x5C, last):
  - PLL_ARST_N stays low throughout;
  - RSP_RDATA=0x5C on the third response;
  - exactly 3 RSP_VALID pulses.
- BUSY held high during WAIT_BUSY with BUSY_TIMEOUT=8:
  - no PSEL ever;
  - RSP_VALID with RSP_ERR=1 and RSP_RDATA=0.
- LOCK never asserts with LOCK_TIMEOUT=20:
  - LOCK_ERR=1 and SEQ_DONE exactly 20 cycles after PLL_ARST_N rises.
  - LOCK_ERR clears on the next sequence's first accept.
- PRESET asserted during ACCESS:
  - PSEL/PENABLE=0 and PLL_ARST_N=1 immediately; no RSP_VALID.
  - The bench then reruns a write and checks it completes normally.
- CMD_VALID held high back-to-back: CMD_READY is high only in IDLE, and the bench checks one accept per 5 cycles.
